fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Beat counter must reach MAX_BURST-1, so one extra code is kept for headroom.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first eligible request at or above ptr_i, wrapping at NREQ-1.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic [NREQ-1:0] mask_i,
    output logic            hit_o,
    output logic [IW-1:0]   idx_o
);

    logic [NREQ-1:0] elig;

    assign elig = req_i & ~mask_i;

    // Walk offsets from farthest to nearest so the nearest eligible slot wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (elig[j]) begin
                hit_o = 1'b1;
                idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                     ck,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_write,
    output logic [WIDTH-1:0]         fifo_datain,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(MAX_BURST);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_q, beat_d;

    logic [NREQ-1:0] grant_oh;
    logic [WIDTH-1:0] req_word [NREQ];
    logic            in_busy;
    logic            transfer;
    logic            release_now;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   pick_ptr;
    logic [NREQ-1:0] pick_mask;
    logic            pick_hit;
    logic [IW-1:0]   pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign grant_oh[gi] = (grant_q == IW'(gi));
            assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign in_busy     = (state_q == ST_BUSY);
    assign transfer    = in_busy & req_valid[grant_q] & ~fifo_full;
    assign release_now = transfer & (req_last[grant_q] | (beat_q == CW'(MAX_BURST - 1)));
    assign next_ptr    = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    // One encoder serves both idle arbitration and same-cycle handover on release;
    // on handover the releasing producer is masked so it cannot immediately win again.
    assign pick_ptr  = in_busy ? next_ptr : rr_ptr_q;
    assign pick_mask = in_busy ? grant_oh : '0;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i  (req_valid),
        .ptr_i  (pick_ptr),
        .mask_i (pick_mask),
        .hit_o  (pick_hit),
        .idx_o  (pick_idx)
    );

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_hit) begin
                    state_d = ST_BUSY;
                    grant_d = pick_idx;
                    beat_d  = '0;
                end
            end
            ST_BUSY: begin
                if (transfer) begin
                    beat_d = beat_q + 1'b1;
                end
                if (release_now) begin
                    rr_ptr_d = next_ptr;
                    beat_d   = '0;
                    if (pick_hit) begin
                        grant_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = in_busy;
        grant_id    = grant_q;
        req_ready   = (in_busy & ~fifo_full) ? grant_oh : '0;
        fifo_write  = transfer;
        fifo_datain = req_word[grant_q];
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: behavioural producers plus a write log checked per scenario.
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int MAXB  = 16;

    logic                   ck = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ*WIDTH-1:0]  req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_full;
    logic                   fifo_write;
    logic [WIDTH-1:0]       fifo_datain;
    logic [1:0]             grant_id;
    logic                   busy;

    fifo_wr_arbiter #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ),
        .MAX_BURST (MAXB)
    ) dut (
        .ck          (ck),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_write  (fifo_write),
        .fifo_datain (fifo_datain),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    // Producer model: words remaining, burst length (0 = never last), next sequence, beats in burst
    int cnt[NREQ];
    int blen[NREQ];
    int seq[NREQ];
    int inb[NREQ];
    bit hold[NREQ];

    int          log_c[$];
    logic [31:0] log_d[$];
    int          exp_c[$];
    logic [31:0] exp_d[$];

    logic        s_wr;
    logic [3:0]  s_rdy;
    logic [1:0]  s_grant;

    function automatic logic [31:0] word(input int id, input int s);
        logic [31:0] a;
        logic [31:0] b;
        a = id;
        b = s;
        return {a[7:0], 8'h5A, b[15:0]};
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (cnt[i] > 0) && !hold[i];
            req_last[i]  = (cnt[i] > 0) && (blen[i] != 0) && (inb[i] + 1 == blen[i]);
            req_data[i*WIDTH +: WIDTH] = word(i, seq[i]);
        end
    endtask

    task automatic clear_producers();
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0; blen[i] = 0; seq[i] = 0; inb[i] = 0; hold[i] = 1'b0;
        end
        drive();
    endtask

    // One clock: sample at the falling edge, apply handshakes just after the rising edge.
    task automatic step();
        bit hs[NREQ];
        @(negedge ck);
        cyc++;
        s_wr    = fifo_write;
        s_rdy   = req_ready;
        s_grant = grant_id;
        for (int i = 0; i < NREQ; i++) hs[i] = req_valid[i] && req_ready[i];
        if (fifo_write) begin
            log_c.push_back(cyc - base);
            log_d.push_back(fifo_datain);
        end
        @(posedge ck);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                if (req_last[i]) inb[i] = 0; else inb[i]++;
                seq[i]++;
                cnt[i]--;
            end
        end
        drive();
    endtask

    task automatic begin_test();
        log_c.delete(); log_d.delete(); exp_c.delete(); exp_d.delete();
        base = cyc;
    endtask

    task automatic expect_seg(input int id, input int s0, input int n, input int c0);
        for (int k = 0; k < n; k++) begin
            exp_c.push_back(c0 + k);
            exp_d.push_back(word(id, s0 + k));
        end
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        clear_producers();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        clear_producers();
        req_valid = 4'hF;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset_write got %0b want 0", fifo_write); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %h want 0", req_ready); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        apply_reset();
        $display("test_reset done");
    endtask

    task automatic test_single_burst();
        apply_reset();
        begin_test();
        cnt[0] = 5; blen[0] = 5;
        drive();
        for (int n = 0; n < 8; n++) step();
        expect_seg(0, 0, 5, 2);
        checks++;
        if (log_c.size() != exp_c.size()) begin
            errors++; $display("FAIL single_count got %0d want %0d", log_c.size(), exp_c.size());
        end
        for (int k = 0; k < log_c.size() && k < exp_c.size(); k++) begin
            checks++;
            if (log_c[k] !== exp_c[k] || log_d[k] !== exp_d[k]) begin
                errors++; $display("FAIL single_w%0d got cyc %0d data %h want cyc %0d data %h", k, log_c[k], log_d[k], exp_c[k], exp_d[k]);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle busy got %0b want 0", busy); end
        checks++; if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL single_rrptr got %0d want 1", dut.rr_ptr_q); end
        $display("test_single_burst: %0d writes", log_c.size());
    endtask

    task automatic test_round_robin();
        apply_reset();
        begin_test();
        for (int i = 0; i < NREQ; i++) begin cnt[i] = 1; blen[i] = 1; end
        cnt[0] = 2;
        drive();
        for (int n = 0; n < 8; n++) step();
        expect_seg(0, 0, 1, 2);
        expect_seg(1, 0, 1, 3);
        expect_seg(2, 0, 1, 4);
        expect_seg(3, 0, 1, 5);
        expect_seg(0, 1, 1, 6);
        checks++;
        if (log_c.size() != exp_c.size()) begin
            errors++; $display("FAIL rr_count got %0d want %0d", log_c.size(), exp_c.size());
        end
        for (int k = 0; k < log_c.size() && k < exp_c.size(); k++) begin
            checks++;
            if (log_c[k] !== exp_c[k] || log_d[k] !== exp_d[k]) begin
                errors++; $display("FAIL rr_w%0d got cyc %0d data %h want cyc %0d data %h", k, log_c[k], log_d[k], exp_c[k], exp_d[k]);
            end
        end
        $display("test_round_robin: %0d writes", log_c.size());
    endtask

    task automatic test_max_burst();
        apply_reset();
        begin_test();
        cnt[2] = 40; blen[2] = 0;
        cnt[3] = 3;  blen[3] = 3;
        drive();
        for (int n = 0; n < 46; n++) step();
        expect_seg(2, 0, 16, 2);
        expect_seg(3, 0, 3, 18);
        expect_seg(2, 16, 16, 21);
        expect_seg(2, 32, 8, 38);
        checks++;
        if (log_c.size() != exp_c.size()) begin
            errors++; $display("FAIL maxb_count got %0d want %0d", log_c.size(), exp_c.size());
        end
        for (int k = 0; k < log_c.size() && k < exp_c.size(); k++) begin
            checks++;
            if (log_c[k] !== exp_c[k] || log_d[k] !== exp_d[k]) begin
                errors++; $display("FAIL maxb_w%0d got cyc %0d data %h want cyc %0d data %h", k, log_c[k], log_d[k], exp_c[k], exp_d[k]);
            end
        end
        $display("test_max_burst: %0d writes", log_c.size());
    endtask

    task automatic test_fifo_full();
        apply_reset();
        begin_test();
        cnt[1] = 8; blen[1] = 8;
        drive();
        for (int n = 0; n < 4; n++) step();
        fifo_full = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (s_wr !== 1'b0 || s_rdy !== 4'h0 || s_grant !== 2'd1) begin
                errors++; $display("FAIL full_hold%0d got wr %0b rdy %h grant %0d want 0 0 1", n, s_wr, s_rdy, s_grant);
            end
        end
        fifo_full = 1'b0;
        for (int n = 0; n < 6; n++) step();
        expect_seg(1, 0, 3, 2);
        expect_seg(1, 3, 5, 8);
        checks++;
        if (log_c.size() != exp_c.size()) begin
            errors++; $display("FAIL full_count got %0d want %0d", log_c.size(), exp_c.size());
        end
        for (int k = 0; k < log_c.size() && k < exp_c.size(); k++) begin
            checks++;
            if (log_c[k] !== exp_c[k] || log_d[k] !== exp_d[k]) begin
                errors++; $display("FAIL full_w%0d got cyc %0d data %h want cyc %0d data %h", k, log_c[k], log_d[k], exp_c[k], exp_d[k]);
            end
        end
        $display("test_fifo_full: %0d writes", log_c.size());
    endtask

    task automatic test_owner_stall();
        apply_reset();
        begin_test();
        cnt[0] = 6; blen[0] = 6;
        cnt[1] = 2; blen[1] = 2;
        drive();
        for (int n = 0; n < 3; n++) step();
        hold[0] = 1'b1;
        drive();
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (s_wr !== 1'b0 || s_grant !== 2'd0 || s_rdy[1] !== 1'b0) begin
                errors++; $display("FAIL stall%0d got wr %0b grant %0d rdy %h want 0 0 rdy1=0", n, s_wr, s_grant, s_rdy);
            end
        end
        hold[0] = 1'b0;
        drive();
        for (int n = 0; n < 7; n++) step();
        expect_seg(0, 0, 2, 2);
        expect_seg(0, 2, 4, 8);
        expect_seg(1, 0, 2, 12);
        checks++;
        if (log_c.size() != exp_c.size()) begin
            errors++; $display("FAIL stall_count got %0d want %0d", log_c.size(), exp_c.size());
        end
        for (int k = 0; k < log_c.size() && k < exp_c.size(); k++) begin
            checks++;
            if (log_c[k] !== exp_c[k] || log_d[k] !== exp_d[k]) begin
                errors++; $display("FAIL stall_w%0d got cyc %0d data %h want cyc %0d data %h", k, log_c[k], log_d[k], exp_c[k], exp_d[k]);
            end
        end
        $display("test_owner_stall: %0d writes", log_c.size());
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        begin_test();
        cnt[2] = 6; blen[2] = 6;
        drive();
        for (int n = 0; n < 3; n++) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_write !== 1'b0 || req_ready !== 4'h0 || grant_id !== 2'd0) begin
            errors++; $display("FAIL midrst got busy %0b wr %0b rdy %h grant %0d want 0 0 0 0", busy, fifo_write, req_ready, grant_id);
        end
        cnt[0] = 1; blen[0] = 1;
        cnt[3] = 1; blen[3] = 1;
        drive();
        step();
        step();
        reset_n = 1'b1;
        begin_test();
        for (int n = 0; n < 4; n++) step();
        expect_seg(0, 0, 1, 2);
        expect_seg(2, 2, 1, 3);
        checks++;
        if (log_c.size() < 2) begin
            errors++; $display("FAIL midrst_count got %0d want >=2", log_c.size());
        end
        for (int k = 0; k < log_c.size() && k < exp_c.size(); k++) begin
            checks++;
            if (log_c[k] !== exp_c[k] || log_d[k] !== exp_d[k]) begin
                errors++; $display("FAIL midrst_w%0d got cyc %0d data %h want cyc %0d data %h", k, log_c[k], log_d[k], exp_c[k], exp_d[k]);
            end
        end
        $display("test_reset_mid_burst: %0d writes", log_c.size());
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_fifo_full();
        test_owner_stall();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
